// File: rtl/multi_player_ctl_pkg.sv
// rtl/multi_player_ctl_pkg.sv - shared types and screen geometry for the player position controller
package multi_player_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } move_t;

  localparam int SCREEN_W      = 1024;
  localparam int SPRITE_W      = 64;
  localparam int X_MAX_DEFAULT = SCREEN_W - SPRITE_W;

  function automatic int clamp_pos(input int pos, input int lo, input int hi);
    if (pos < lo) return lo;
    if (pos > hi) return hi;
    return pos;
  endfunction

endpackage

// File: rtl/multi_player_ctl_player_axis_ch.sv
// rtl/multi_player_ctl_player_axis_ch.sv - one player channel: request latch, move FSM, hold ramp, clamp
module player_axis_ch
  import multi_player_ctl_pkg::*;
#(
  parameter int XPOS_W      = 12,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 960,
  parameter int X_RESET     = 256,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 6,
  parameter int HOLD_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_edge,
  input  logic              enable,
  input  logic              zero,
  input  logic              left_s,
  input  logic              right_s,
  output logic [XPOS_W-1:0] xpos,
  output logic              moving
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0]          HOLD_SAT = HW'(HOLD_FRAMES);
  localparam logic signed [XPOS_W:0] LO       = (XPOS_W+1)'(X_MIN);
  localparam logic signed [XPOS_W:0] HI       = (XPOS_W+1)'(X_MAX);
  localparam logic signed [XPOS_W:0] STEP_LO  = (XPOS_W+1)'(STEP_MIN);
  localparam logic signed [XPOS_W:0] STEP_HI  = (XPOS_W+1)'(STEP_MAX);
  localparam logic [XPOS_W-1:0]      POS_RST  = XPOS_W'(X_RESET);

  move_t                   state;
  move_t                   nxt;
  logic                    lreq;
  logic                    rreq;
  logic                    l_c;
  logic                    r_c;
  logic [HW-1:0]           hold;
  logic [HW-1:0]           hold_nxt;
  logic                    fast;
  logic signed [XPOS_W:0]  step;
  logic signed [XPOS_W:0]  cur;
  logic signed [XPOS_W:0]  nxt_pos;

  always_comb begin
    l_c = lreq | left_s;
    r_c = rreq | right_s;

    nxt = IDLE;
    if (l_c && !r_c)      nxt = MOVE_L;
    else if (r_c && !l_c) nxt = MOVE_R;

    if (nxt == IDLE)            hold_nxt = '0;
    else if (nxt != state)      hold_nxt = HW'(1);
    else if (hold == HOLD_SAT)  hold_nxt = hold;
    else                        hold_nxt = hold + HW'(1);

    // Fast only once the counter was already full, so the first fast frame is HOLD_FRAMES+1.
    fast = (nxt != IDLE) && (nxt == state) && (hold == HOLD_SAT);
    step = fast ? STEP_HI : STEP_LO;

    cur     = {1'b0, xpos};
    nxt_pos = cur;
    if (nxt == MOVE_L) begin
      nxt_pos = cur - step;
      if (nxt_pos < LO) nxt_pos = LO;
    end else if (nxt == MOVE_R) begin
      nxt_pos = cur + step;
      if (nxt_pos > HI) nxt_pos = HI;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || zero) begin
      xpos   <= POS_RST;
      moving <= 1'b0;
      state  <= IDLE;
      hold   <= '0;
      lreq   <= 1'b0;
      rreq   <= 1'b0;
    end else if (frame_edge) begin
      lreq <= 1'b0;
      rreq <= 1'b0;
      if (!enable) begin
        state  <= IDLE;
        hold   <= '0;
        moving <= 1'b0;
      end else begin
        state  <= nxt;
        hold   <= hold_nxt;
        xpos   <= nxt_pos[XPOS_W-1:0];
        moving <= (nxt_pos != cur);
      end
    end else begin
      lreq <= l_c;
      rreq <= r_c;
    end
  end

endmodule

// File: rtl/multi_player_ctl.sv
// rtl/multi_player_ctl.sv - N-player horizontal position controller updated once per vsync rise
module multi_player_ctl
  import multi_player_ctl_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int XPOS_W      = 12,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = X_MAX_DEFAULT,
  parameter int X_INIT      = 256,
  parameter int X_SPACING   = 512,
  parameter int STEP_MIN    = 2,
  parameter int STEP_MAX    = 6,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          v_tick,
  input  logic                          enable,
  input  logic                          zero,
  input  logic [N_PLAYERS-1:0]          left,
  input  logic [N_PLAYERS-1:0]          right,
  output logic [N_PLAYERS*XPOS_W-1:0]   xpos,
  output logic [N_PLAYERS-1:0]          moving,
  output logic                          frame_stb
);

  logic [N_PLAYERS-1:0] left_s1;
  logic [N_PLAYERS-1:0] left_s;
  logic [N_PLAYERS-1:0] right_s1;
  logic [N_PLAYERS-1:0] right_s;
  logic                 vt_s1;
  logic                 vt_s;
  logic                 vt_s_d;
  logic                 frame_edge;

  assign frame_edge = vt_s & ~vt_s_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      left_s1   <= '0;
      left_s    <= '0;
      right_s1  <= '0;
      right_s   <= '0;
      vt_s1     <= 1'b0;
      vt_s      <= 1'b0;
      vt_s_d    <= 1'b0;
      frame_stb <= 1'b0;
    end else begin
      left_s1   <= left;
      left_s    <= left_s1;
      right_s1  <= right;
      right_s   <= right_s1;
      vt_s1     <= v_tick;
      vt_s      <= vt_s1;
      vt_s_d    <= vt_s;
      frame_stb <= frame_edge;
    end
  end

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    player_axis_ch #(
      .XPOS_W      (XPOS_W),
      .X_MIN       (X_MIN),
      .X_MAX       (X_MAX),
      .X_RESET     (clamp_pos(X_INIT + i * X_SPACING, X_MIN, X_MAX)),
      .STEP_MIN    (STEP_MIN),
      .STEP_MAX    (STEP_MAX),
      .HOLD_FRAMES (HOLD_FRAMES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .frame_edge (frame_edge),
      .enable     (enable),
      .zero       (zero),
      .left_s     (left_s[i]),
      .right_s    (right_s[i]),
      .xpos       (xpos[i*XPOS_W +: XPOS_W]),
      .moving     (moving[i])
    );
  end

endmodule

// File: tb/tb_multi_player_ctl.sv
// tb/tb_multi_player_ctl.sv - directed vector bench for the N-player position controller
module tb_multi_player_ctl;

  localparam int N = 2;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           v_tick = 1'b0;
  logic           enable = 1'b1;
  logic           zero = 1'b0;
  logic [N-1:0]   left = '0;
  logic [N-1:0]   right = '0;
  logic [N*W-1:0] xpos;
  logic [N-1:0]   moving;
  logic           frame_stb;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] l;
    logic [1:0] r;
    logic       en;
    int         x0;
    int         x1;
    int         mov;
  } vec_t;

  vec_t tbl[24];
  vec_t tbl_en[3];

  multi_player_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .v_tick    (v_tick),
    .enable    (enable),
    .zero      (zero),
    .left      (left),
    .right     (right),
    .xpos      (xpos),
    .moving    (moving),
    .frame_stb (frame_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int e0, input int e1, input int em);
    chk({tag, " xpos0"}, int'(xpos[W-1:0]), e0);
    chk({tag, " xpos1"}, int'(xpos[2*W-1:W]), e1);
    chk({tag, " moving"}, int'(moving), em);
  endtask

  // Requests are raised for a few cycles, then dropped together with the v_tick rise.
  task automatic frame(input logic [1:0] l, input logic [1:0] r, input string tag,
                       input int e0, input int e1, input int em);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    left  = l;
    right = r;
    repeat (4) @(negedge clk);
    v_tick = 1'b1;
    left   = '0;
    right  = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (frame_stb) seen = 1'b1;
    end
    chk({tag, " frame_stb"}, int'(seen), 1);
    check_state(tag, e0, e1, em);
    @(negedge clk);
    chk({tag, " stb width"}, int'(frame_stb), 0);
    v_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{2'b00, 2'b10, 1'b1, 254, 770, 2};
    tbl[1]  = '{2'b00, 2'b10, 1'b1, 254, 772, 2};
    tbl[2]  = '{2'b00, 2'b10, 1'b1, 254, 774, 2};
    tbl[3]  = '{2'b00, 2'b10, 1'b1, 254, 776, 2};
    tbl[4]  = '{2'b00, 2'b10, 1'b1, 254, 778, 2};
    tbl[5]  = '{2'b00, 2'b10, 1'b1, 254, 780, 2};
    tbl[6]  = '{2'b00, 2'b10, 1'b1, 254, 782, 2};
    tbl[7]  = '{2'b00, 2'b10, 1'b1, 254, 784, 2};
    tbl[8]  = '{2'b00, 2'b10, 1'b1, 254, 790, 2};
    tbl[9]  = '{2'b00, 2'b10, 1'b1, 254, 796, 2};
    tbl[10] = '{2'b00, 2'b10, 1'b1, 254, 802, 2};
    tbl[11] = '{2'b00, 2'b10, 1'b1, 254, 808, 2};
    tbl[12] = '{2'b01, 2'b00, 1'b1, 252, 808, 1};
    tbl[13] = '{2'b01, 2'b00, 1'b1, 250, 808, 1};
    tbl[14] = '{2'b01, 2'b00, 1'b1, 248, 808, 1};
    tbl[15] = '{2'b01, 2'b00, 1'b1, 246, 808, 1};
    tbl[16] = '{2'b01, 2'b00, 1'b1, 244, 808, 1};
    tbl[17] = '{2'b01, 2'b00, 1'b1, 242, 808, 1};
    tbl[18] = '{2'b01, 2'b00, 1'b1, 240, 808, 1};
    tbl[19] = '{2'b01, 2'b00, 1'b1, 238, 808, 1};
    tbl[20] = '{2'b01, 2'b00, 1'b1, 232, 808, 1};
    tbl[21] = '{2'b01, 2'b01, 1'b1, 232, 808, 0};
    tbl[22] = '{2'b01, 2'b00, 1'b1, 230, 808, 1};
    tbl[23] = '{2'b00, 2'b00, 1'b1, 230, 808, 0};

    tbl_en[0] = '{2'b10, 2'b01, 1'b0, 0, 960, 0};
    tbl_en[1] = '{2'b00, 2'b00, 1'b1, 0, 960, 0};
    tbl_en[2] = '{2'b10, 2'b01, 1'b1, 2, 958, 3};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_state("reset", 256, 768, 0);
    chk("reset stb", int'(frame_stb), 0);
    repeat (4) begin
      @(negedge clk);
      chk("idle stb", int'(frame_stb), 0);
    end

    // single-cycle left pulse mid-frame must survive until the next frame
    @(negedge clk);
    left = 2'b01;
    @(negedge clk);
    left = 2'b00;
    repeat (3) @(negedge clk);
    frame(2'b00, 2'b00, "pulse", 254, 768, 1);
    frame(2'b00, 2'b00, "pulse idle", 254, 768, 0);

    for (int i = 0; i < 24; i++) begin
      enable = tbl[i].en;
      frame(tbl[i].l, tbl[i].r, $sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].mov);
    end

    // long hold into both play-field boundaries
    for (int f = 1; f <= 45; f++) begin
      int e0;
      int e1;
      int em;
      e0 = (f <= 8) ? 230 - 2*f : ((f <= 43) ? 214 - 6*(f-8) : 0);
      e1 = (f <= 8) ? 808 + 2*f : ((f <= 30) ? 824 + 6*(f-8) : 960);
      em = ((f <= 44) ? 1 : 0) | ((f <= 31) ? 2 : 0);
      frame(2'b01, 2'b10, $sformatf("ramp%0d", f), e0, e1, em);
    end

    for (int i = 0; i < 3; i++) begin
      enable = tbl_en[i].en;
      frame(tbl_en[i].l, tbl_en[i].r, $sformatf("en%0d", i),
            tbl_en[i].x0, tbl_en[i].x1, tbl_en[i].mov);
    end
    enable = 1'b1;

    // zero lands on the same cycle as the frame edge
    @(negedge clk);
    left = 2'b11;
    repeat (4) @(negedge clk);
    v_tick = 1'b1;
    left   = '0;
    @(negedge clk);
    @(negedge clk);
    zero = 1'b1;
    @(negedge clk);
    zero = 1'b0;
    chk("zero stb", int'(frame_stb), 1);
    check_state("zero edge", 256, 768, 0);
    @(negedge clk);
    v_tick = 1'b0;
    repeat (3) @(negedge clk);
    frame(2'b00, 2'b00, "post zero", 256, 768, 0);

    // reset mid-frame with requests in flight
    frame(2'b01, 2'b00, "pre rst", 254, 768, 1);
    @(negedge clk);
    left = 2'b11;
    repeat (2) @(negedge clk);
    left = '0;
    rst  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_state("mid rst", 256, 768, 0);
    chk("mid rst stb", int'(frame_stb), 0);
    frame(2'b00, 2'b00, "post rst", 256, 768, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
